// File: rtl/tdm_link_pkg.sv
// Shared definitions for both ends of the 2-channel TDM serial link.
package tdm_link_pkg;
   localparam int   DEF_WIDTH = 8;
   localparam int   NUM_CH    = 2;
   localparam logic CH0       = 1'b0;
   localparam logic CH1       = 1'b1;

   typedef enum logic {
      LANE_EMPTY = 1'b0,
      LANE_FULL  = 1'b1
   } lane_state_t;
endpackage

// File: rtl/tdm_demux2_deser_if.sv
// Serial link input plus per-channel valid/ready word outputs of the TDM receiver.
interface tdm_demux2_deser_if #(
   parameter int WIDTH = tdm_link_pkg::DEF_WIDTH
);
   logic             clr;
   logic             din;
   logic             din_sel;
   logic             din_valid;
   logic [WIDTH-1:0] ch0_data;
   logic             ch0_valid;
   logic             ch0_ready;
   logic [WIDTH-1:0] ch1_data;
   logic             ch1_valid;
   logic             ch1_ready;
   logic [1:0]       overflow;

   modport master (
      output clr, din, din_sel, din_valid, ch0_ready, ch1_ready,
      input  ch0_data, ch0_valid, ch1_data, ch1_valid, overflow
   );

   modport slave (
      input  clr, din, din_sel, din_valid, ch0_ready, ch1_ready,
      output ch0_data, ch0_valid, ch1_data, ch1_valid, overflow
   );
endinterface

// File: rtl/tdm_demux2_deser_lane.sv
// One receive lane: shift register, bit counter, single-entry output register, sticky overflow.
// Word valid on the edge sampling its last bit; a word completing into a full, unaccepted register is dropped.
module tdm_deser_lane
   import tdm_link_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_shift,
   input  logic             i_bit,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_ovf
);
   logic [WIDTH-2:0] r_sh;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_data;
   logic             r_ovf;
   lane_state_t      r_state;

   lane_state_t      w_state_nxt;
   logic             w_done;
   logic             w_load;
   logic             w_ovf_set;
   logic [WIDTH-1:0] w_word;

   // clr discards a same-cycle bit, so it also suppresses completion
   assign w_done = i_shift && !i_clr && (r_cnt == CNT_W'(WIDTH - 1));
   assign w_word = {r_sh, i_bit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh  <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         r_sh  <= '0;
         r_cnt <= '0;
      end else if (i_shift) begin
         r_sh  <= w_word[WIDTH-2:0];
         r_cnt <= w_done ? '0 : r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_ovf_set   = 1'b0;
      case (r_state)
         LANE_EMPTY: begin
            if (w_done) begin
               w_load      = 1'b1;
               w_state_nxt = LANE_FULL;
            end
         end
         LANE_FULL: begin
            if (w_done) begin
               w_load    = i_ready;
               w_ovf_set = !i_ready;
            end else if (i_ready) begin
               w_state_nxt = LANE_EMPTY;
            end
         end
         default: w_state_nxt = LANE_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LANE_EMPTY;
         r_data  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load)    r_data <= w_word;
         if (w_ovf_set) r_ovf  <= 1'b1;
      end
   end

   assign o_data  = r_data;
   assign o_valid = (r_state == LANE_FULL);
   assign o_ovf   = r_ovf;
endmodule

// File: rtl/tdm_demux2_deser.sv
// 2-channel TDM receiver: steers each valid serial bit to the lane named by din_sel.
// Words appear one edge after their last bit; per-lane valid/ready with drop-and-flag on overflow.
module tdm_demux2_deser
   import tdm_link_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic                clk,
   input logic                rst_n,
   tdm_demux2_deser_if.slave  bus
);
   logic [NUM_CH-1:0] w_shift;
   logic [NUM_CH-1:0] w_ovf;

   assign w_shift[0] = bus.din_valid && (bus.din_sel == CH0);
   assign w_shift[1] = bus.din_valid && (bus.din_sel == CH1);

   tdm_deser_lane #(.WIDTH(WIDTH)) u_lane0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (bus.clr),
      .i_shift (w_shift[0]),
      .i_bit   (bus.din),
      .i_ready (bus.ch0_ready),
      .o_data  (bus.ch0_data),
      .o_valid (bus.ch0_valid),
      .o_ovf   (w_ovf[0])
   );

   tdm_deser_lane #(.WIDTH(WIDTH)) u_lane1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (bus.clr),
      .i_shift (w_shift[1]),
      .i_bit   (bus.din),
      .i_ready (bus.ch1_ready),
      .o_data  (bus.ch1_data),
      .o_valid (bus.ch1_valid),
      .o_ovf   (w_ovf[1])
   );

   assign bus.overflow = w_ovf;
endmodule
